// File: rtl/bp_me_burst_rr_mux.sv
// N-to-1 round-robin mux for BedRock header+data burst streams.
// A granted channel owns the output link until its header and every data beat have been sent.
module bp_me_burst_rr_mux #(
  parameter int unsigned num_ch_p       = 3,
  parameter int unsigned header_width_p = 96,
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned size_lsb_p     = 0,
  parameter int unsigned type_lsb_p     = 3,
  parameter logic [15:0] data_types_p   = 16'h0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_ch_p*header_width_p-1:0]   in_header_i,
  input  logic [num_ch_p-1:0]                  in_header_v_i,
  output logic [num_ch_p-1:0]                  in_header_ready_and_o,
  input  logic [num_ch_p*data_width_p-1:0]     in_data_i,
  input  logic [num_ch_p-1:0]                  in_data_v_i,
  output logic [num_ch_p-1:0]                  in_data_ready_and_o,
  output logic [header_width_p-1:0]            out_header_o,
  output logic                                 out_header_v_o,
  input  logic                                 out_header_ready_and_i,
  output logic [data_width_p-1:0]              out_data_o,
  output logic                                 out_data_v_o,
  input  logic                                 out_data_ready_and_i,
  output logic [((num_ch_p > 1) ? $clog2(num_ch_p) : 1)-1:0] grant_id_o
);

  localparam int unsigned grant_w = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int unsigned cnt_w   = $clog2(1024 / data_width_p + 1);
  localparam int unsigned beat_lg = $clog2(data_width_p);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

  state_e               state;
  logic [grant_w-1:0]   rr_ptr;
  logic [grant_w-1:0]   grant;
  logic [cnt_w-1:0]     beat_cnt;

  logic [2*num_ch_p-1:0] req_dbl;
  logic                  arb_found;
  logic [grant_w-1:0]    arb_off;
  logic [grant_w:0]      arb_sum;
  logic [grant_w-1:0]    arb_id;
  logic [grant_w-1:0]    ptr_inc;

  logic                  hdr_v_sel;
  logic                  data_v_sel;
  logic                  hdr_hs;
  logic                  data_hs;

  logic [2:0]            msg_size;
  logic [3:0]            msg_type;
  logic                  has_data;
  logic [10:0]           msg_bits;
  logic [10:0]           beats;
  logic [cnt_w-1:0]      beats_m1;

  // Rotate requests so the search starts at rr_ptr, then map the offset back to a channel id.
  always_comb begin
    req_dbl   = {in_header_v_i, in_header_v_i} >> rr_ptr;
    arb_found = 1'b0;
    arb_off   = '0;
    for (int unsigned k = 0; k < num_ch_p; k++) begin
      if (!arb_found && req_dbl[k]) begin
        arb_found = 1'b1;
        arb_off   = grant_w'(k);
      end
    end
    arb_sum = (grant_w+1)'(rr_ptr) + (grant_w+1)'(arb_off);
    if (arb_sum >= (grant_w+1)'(num_ch_p)) begin
      arb_sum = arb_sum - (grant_w+1)'(num_ch_p);
    end
    arb_id = grant_w'(arb_sum);
  end

  assign ptr_inc = (grant == grant_w'(num_ch_p - 1)) ? '0 : grant + 1'b1;

  // Steer the granted channel onto the output; only that channel ever sees a ready.
  always_comb begin
    out_header_o          = '0;
    out_data_o            = '0;
    hdr_v_sel             = 1'b0;
    data_v_sel            = 1'b0;
    in_header_ready_and_o = '0;
    in_data_ready_and_o   = '0;
    for (int unsigned i = 0; i < num_ch_p; i++) begin
      if (grant == grant_w'(i)) begin
        out_header_o           = in_header_i[i*header_width_p +: header_width_p];
        out_data_o             = in_data_i[i*data_width_p +: data_width_p];
        hdr_v_sel              = in_header_v_i[i];
        data_v_sel             = in_data_v_i[i];
        in_header_ready_and_o[i] = (state == HEADER) && out_header_ready_and_i;
        in_data_ready_and_o[i]   = (state == DATA) && out_data_ready_and_i;
      end
    end
    out_header_v_o = (state == HEADER) && hdr_v_sel;
    out_data_v_o   = (state == DATA) && data_v_sel;
  end

  assign hdr_hs  = out_header_v_o && out_header_ready_and_i;
  assign data_hs = out_data_v_o && out_data_ready_and_i;

  // Beat count of the header on the output: max(1, message bits / beat width).
  always_comb begin
    msg_size = out_header_o[size_lsb_p +: 3];
    msg_type = out_header_o[type_lsb_p +: 4];
    has_data = data_types_p[msg_type];
    msg_bits = 11'd8 << msg_size;
    beats    = msg_bits >> beat_lg;
    if (beats == '0) begin
      beats = 11'd1;
    end
    beats_m1 = cnt_w'(beats - 11'd1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_id;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (hdr_hs) begin
            if (has_data) begin
              beat_cnt <= beats_m1;
              state    <= DATA;
            end else begin
              rr_ptr <= ptr_inc;
              state  <= IDLE;
            end
          end
        end
        DATA: begin
          if (data_hs) begin
            if (beat_cnt == '0) begin
              rr_ptr <= ptr_inc;
              state  <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id_o = grant;

endmodule

// File: tb/tb_bp_me_burst_rr_mux.sv
// Bench for bp_me_burst_rr_mux: directed scenarios plus a randomized run against a
// message-level round-robin scoreboard.
module tb_bp_me_burst_rr_mux;

  localparam int NCH = 3;
  localparam int HW  = 96;
  localparam int DW  = 64;
  localparam int DWW = 128;
  localparam logic [15:0] DTYPES = 16'h00F0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH*HW-1:0] in_header;
  logic [NCH-1:0]    in_header_v;
  logic [NCH-1:0]    hdr_rdy;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_data_v;
  logic [NCH-1:0]    data_rdy;
  logic [HW-1:0]     out_header;
  logic              out_header_v;
  logic              out_header_rdy;
  logic [DW-1:0]     out_data;
  logic              out_data_v;
  logic              out_data_rdy;
  logic [1:0]        grant;

  logic [HW-1:0]     w_in_header;
  logic [0:0]        w_in_header_v;
  logic [0:0]        w_hdr_rdy;
  logic [DWW-1:0]    w_in_data;
  logic [0:0]        w_in_data_v;
  logic [0:0]        w_data_rdy;
  logic [HW-1:0]     w_out_header;
  logic              w_out_header_v;
  logic              w_out_header_rdy;
  logic [DWW-1:0]    w_out_data;
  logic              w_out_data_v;
  logic              w_out_data_rdy;
  logic [0:0]        w_grant;

  int checks = 0;
  int errors = 0;

  bp_me_burst_rr_mux #(
    .num_ch_p(NCH), .header_width_p(HW), .data_width_p(DW),
    .size_lsb_p(0), .type_lsb_p(3), .data_types_p(DTYPES)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .in_header_i(in_header), .in_header_v_i(in_header_v), .in_header_ready_and_o(hdr_rdy),
    .in_data_i(in_data), .in_data_v_i(in_data_v), .in_data_ready_and_o(data_rdy),
    .out_header_o(out_header), .out_header_v_o(out_header_v), .out_header_ready_and_i(out_header_rdy),
    .out_data_o(out_data), .out_data_v_o(out_data_v), .out_data_ready_and_i(out_data_rdy),
    .grant_id_o(grant)
  );

  bp_me_burst_rr_mux #(
    .num_ch_p(1), .header_width_p(HW), .data_width_p(DWW),
    .size_lsb_p(0), .type_lsb_p(3), .data_types_p(DTYPES)
  ) dut_w (
    .clk_i(clk), .reset_i(rst),
    .in_header_i(w_in_header), .in_header_v_i(w_in_header_v), .in_header_ready_and_o(w_hdr_rdy),
    .in_data_i(w_in_data), .in_data_v_i(w_in_data_v), .in_data_ready_and_o(w_data_rdy),
    .out_header_o(w_out_header), .out_header_v_o(w_out_header_v), .out_header_ready_and_i(w_out_header_rdy),
    .out_data_o(w_out_data), .out_data_v_o(w_out_data_v), .out_data_ready_and_i(w_out_data_rdy),
    .grant_id_o(w_grant)
  );

  function automatic logic [HW-1:0] make_hdr(int mtype, int size);
    logic [HW-1:0] h;
    h = {$urandom, $urandom, $urandom};
    h[2:0] = 3'(size);
    h[6:3] = 4'(mtype);
    return h;
  endfunction

  // Reference beat count: message bytes = 2^size, at least one beat for data-carrying types.
  function automatic int exp_beats(logic [HW-1:0] h, int dw);
    int bits;
    if (!DTYPES[h[6:3]]) return 0;
    bits = 8 * (1 << h[2:0]);
    return (bits < dw) ? 1 : bits / dw;
  endfunction

  task automatic idle_inputs();
    in_header = '0; in_header_v = '0; in_data = '0; in_data_v = '0;
    out_header_rdy = 1'b0; out_data_rdy = 1'b0;
    w_in_header = '0; w_in_header_v = '0; w_in_data = '0; w_in_data_v = '0;
    w_out_header_rdy = 1'b0; w_out_data_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    in_header_v = '1;
    out_header_rdy = 1'b1;
    out_data_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    checks++; if (out_header_v !== 1'b0) begin errors++; $display("FAIL reset_hdr_v: got %0b expected 0", out_header_v); end
    checks++; if (out_data_v !== 1'b0) begin errors++; $display("FAIL reset_data_v: got %0b expected 0", out_data_v); end
    checks++; if (hdr_rdy !== 3'b000) begin errors++; $display("FAIL reset_hdr_rdy: got %b expected 000", hdr_rdy); end
    checks++; if (data_rdy !== 3'b000) begin errors++; $display("FAIL reset_data_rdy: got %b expected 000", data_rdy); end
    checks++; if (w_out_header_v !== 1'b0 || w_grant !== 1'b0) begin errors++; $display("FAIL reset_wide: got v=%0b g=%0d expected 0 0", w_out_header_v, w_grant); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_reset_mid_data();
    logic [HW-1:0] h;
    int sent;
    bit hdr_done, hit;
    do_reset();
    h = make_hdr(4, 6);
    sent = 0; hdr_done = 0; hit = 0;
    out_header_rdy = 1'b1;
    out_data_rdy = 1'b1;
    for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
      @(negedge clk);
      in_header[HW +: HW] = h;
      in_header_v[1] = !hdr_done;
      in_data[DW +: DW] = DW'(64'hA0 + 64'(sent));
      in_data_v[1] = 1'b1;
      #1;
      if (out_header_v && out_header_rdy) hdr_done = 1;
      if (out_data_v && out_data_rdy) begin sent++; if (sent == 3) hit = 1; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL middata_setup: got %0d beats expected 3", sent); end
    @(negedge clk);
    #1;
    checks++; if (out_data_v !== 1'b1 || grant !== 2'd1) begin errors++; $display("FAIL middata_busy: got v=%0b g=%0d expected 1 1", out_data_v, grant); end
    rst = 1'b1;
    #1;
    checks++; if (out_data_v !== 1'b0 || out_header_v !== 1'b0) begin errors++; $display("FAIL middata_rst_v: got %0b%0b expected 00", out_header_v, out_data_v); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL middata_rst_grant: got %0d expected 0", grant); end
    checks++; if (data_rdy !== 3'b000) begin errors++; $display("FAIL middata_rst_rdy: got %b expected 000", data_rdy); end
    @(negedge clk);
    rst = 1'b0;
    in_header[0 +: HW] = make_hdr(0, 0);
    in_header_v = 3'b011;
    #1;
    checks++; if (hdr_rdy !== 3'b000 || out_header_v !== 1'b0 || out_data_v !== 1'b0) begin errors++; $display("FAIL middata_idle: got rdy=%b hv=%0b dv=%0b expected 000 0 0", hdr_rdy, out_header_v, out_data_v); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 2'd0 || out_header_v !== 1'b1) begin errors++; $display("FAIL middata_regrant: got g=%0d v=%0b expected 0 1", grant, out_header_v); end
    idle_inputs();
  endtask

  task automatic test_rr_order();
    logic [HW-1:0] hdr [3][2];
    int rem [3];
    int idx [3];
    int exp_ch [4];
    int exp_cyc [4];
    int n, e;
    exp_ch = '{0, 1, 2, 0};
    exp_cyc = '{1, 3, 5, 7};
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 2; k++) hdr[c][k] = make_hdr(c, k + 1);
    rem = '{2, 1, 1};
    idx = '{0, 0, 0};
    n = 0;
    do_reset();
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      @(negedge clk);
      out_header_rdy = 1'b1;
      out_data_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
        in_header_v[c] = (rem[c] > 0);
        if (rem[c] > 0) in_header[c*HW +: HW] = hdr[c][idx[c]];
      end
      #1;
      if (out_header_v && out_header_rdy) begin
        e = exp_ch[n];
        checks++; if (grant !== 2'(e)) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", n, grant, e); end
        checks++; if (out_header !== hdr[e][idx[e]]) begin errors++; $display("FAIL rr_header%0d: got %h expected %h", n, out_header, hdr[e][idx[e]]); end
        checks++; if (cyc != exp_cyc[n]) begin errors++; $display("FAIL rr_cycle%0d: got %0d expected %0d", n, cyc, exp_cyc[n]); end
        rem[e]--; idx[e]++; n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", n); end
    idle_inputs();
  endtask

  task automatic test_long_burst();
    logic [HW-1:0] h1, h0;
    logic [DW-1:0] beats [10];
    int n;
    bit h1_done, h0_done, early;
    h1 = make_hdr(5, 6);
    h0 = make_hdr(2, 2);
    for (int b = 0; b < 10; b++) beats[b] = {$urandom, $urandom};
    n = 0; h1_done = 0; h0_done = 0; early = 0;
    do_reset();
    for (int cyc = 0; cyc < 200 && !h0_done; cyc++) begin
      @(negedge clk);
      out_header_rdy = 1'b1;
      out_data_rdy = 1'($urandom_range(0, 1));
      in_header[HW +: HW] = h1;
      in_header_v[1] = !h1_done;
      in_header[0 +: HW] = h0;
      in_header_v[0] = (cyc >= 1) && !h0_done;
      in_data_v[1] = (n < 10);
      in_data[DW +: DW] = beats[(n < 10) ? n : 9];
      #1;
      if (hdr_rdy[0] && n < 8) early = 1;
      if (out_header_v && out_header_rdy) begin
        if (!h1_done) begin
          checks++; if (grant !== 2'd1 || out_header !== h1) begin errors++; $display("FAIL burst_hdr1: got g=%0d h=%h expected 1 %h", grant, out_header, h1); end
          h1_done = 1;
        end else begin
          checks++; if (grant !== 2'd0 || out_header !== h0) begin errors++; $display("FAIL burst_hdr0: got g=%0d h=%h expected 0 %h", grant, out_header, h0); end
          checks++; if (n != 8) begin errors++; $display("FAIL burst_beats_before_ch0: got %0d expected 8", n); end
          h0_done = 1;
        end
      end
      if (out_data_v && out_data_rdy) begin
        checks++;
        if (n >= 10 || out_data !== beats[(n < 10) ? n : 9]) begin
          errors++; $display("FAIL burst_data%0d: got %h expected %h", n, out_data, beats[(n < 10) ? n : 9]);
        end
        n++;
      end
    end
    checks++; if (!h0_done) begin errors++; $display("FAIL burst_timeout: got ch0 pending expected ch0 granted"); end
    checks++; if (early) begin errors++; $display("FAIL burst_ch0_early: got ready expected none before beat 8"); end
    checks++; if (n != 8) begin errors++; $display("FAIL burst_total: got %0d expected 8", n); end
    idle_inputs();
  endtask

  task automatic test_wide_beat();
    int sizes [4];
    int want [4];
    logic [HW-1:0] h;
    int n, hs_cyc;
    bit done;
    sizes = '{3, 4, 6, 7};
    want = '{1, 1, 4, 8};
    do_reset();
    for (int m = 0; m < 4; m++) begin
      h = make_hdr(6, sizes[m]);
      n = 0; hs_cyc = -1; done = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
        @(negedge clk);
        w_in_header = h;
        w_in_header_v = !done;
        w_in_data = {$urandom, $urandom, $urandom, $urandom};
        w_in_data_v = 1'b1;
        w_out_header_rdy = 1'b1;
        w_out_data_rdy = 1'b1;
        #1;
        if (w_out_header_v && w_out_header_rdy) begin
          done = 1; hs_cyc = cyc;
          checks++; if (w_out_header !== h) begin errors++; $display("FAIL wide_hdr%0d: got %h expected %h", m, w_out_header, h); end
        end
        if (w_out_data_v && w_out_data_rdy) begin
          checks++; if (w_out_data !== w_in_data) begin errors++; $display("FAIL wide_data%0d: got %h expected %h", m, w_out_data, w_in_data); end
          n++;
        end
      end
      checks++; if (hs_cyc != 1) begin errors++; $display("FAIL wide_latency%0d: got %0d expected 1", m, hs_cyc); end
      checks++; if (n != want[m]) begin errors++; $display("FAIL wide_beats_size%0d: got %0d expected %0d", sizes[m], n, want[m]); end
    end
    idle_inputs();
  endtask

  task automatic test_single_requester();
    logic [HW-1:0] hdrs [4];
    int sent;
    bit got;
    for (int k = 0; k < 4; k++) hdrs[k] = make_hdr(k, k);
    sent = 0; got = 0;
    do_reset();
    for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
      @(negedge clk);
      out_header_rdy = 1'b1;
      in_header[2*HW +: HW] = hdrs[(sent < 4) ? sent : 3];
      in_header_v[2] = (sent < 4);
      #1;
      if (out_header_v && out_header_rdy) begin
        checks++; if (grant !== 2'd2 || out_header !== hdrs[sent]) begin errors++; $display("FAIL single_grant%0d: got g=%0d expected 2", sent, grant); end
        checks++; if (cyc != 1 + 2 * sent) begin errors++; $display("FAIL single_cycle%0d: got %0d expected %0d", sent, cyc, 1 + 2 * sent); end
        sent++;
      end
    end
    checks++; if (sent != 4) begin errors++; $display("FAIL single_count: got %0d expected 4", sent); end
    // After ch2 the pointer wraps to 0, so ch1 must win over ch2.
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      in_header[HW +: HW] = hdrs[0];
      in_header_v = 3'b110;
      #1;
      if (out_header_v && out_header_rdy) begin
        got = 1;
        checks++; if (grant !== 2'd1) begin errors++; $display("FAIL single_wrap: got %0d expected 1", grant); end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL single_wrap_timeout: got none expected grant"); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [HW-1:0] hq [NCH][$];
    logic [DW-1:0] dq [NCH][$];
    logic [HW-1:0] h;
    logic [NCH-1:0] exp_drdy;
    int ptr, cur, left, done, exp, cyc, c, nb;
    for (int m = 0; m < 1000; m++) begin
      c = $urandom_range(0, NCH - 1);
      h = make_hdr($urandom_range(0, 15), $urandom_range(0, 7));
      hq[c].push_back(h);
      nb = exp_beats(h, DW);
      for (int b = 0; b < nb; b++) dq[c].push_back({$urandom, $urandom});
    end
    ptr = 0; cur = 0; left = 0; done = 0; cyc = 0;
    do_reset();
    while (done < 1000 && cyc < 60000 && errors <= 20) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) begin
        in_header_v[k] = (hq[k].size() > 0);
        if (hq[k].size() > 0) in_header[k*HW +: HW] = hq[k][0];
        in_data_v[k] = (dq[k].size() > 0) && ($urandom_range(0, 3) != 0);
        if (dq[k].size() > 0) in_data[k*DW +: DW] = dq[k][0];
      end
      out_header_rdy = 1'($urandom_range(0, 1));
      out_data_rdy = 1'($urandom_range(0, 1));
      #1;
      exp_drdy = (left > 0 && out_data_rdy) ? NCH'(1 << cur) : '0;
      checks++; if (data_rdy !== exp_drdy) begin errors++; $display("FAIL rand_data_rdy: got %b expected %b", data_rdy, exp_drdy); end
      if (left > 0) begin
        checks++; if (hdr_rdy !== '0) begin errors++; $display("FAIL rand_hdr_rdy_in_burst: got %b expected 000", hdr_rdy); end
      end
      if (out_header_v && out_header_rdy) begin
        exp = -1;
        for (int k = 0; k < NCH; k++)
          if (exp < 0 && hq[(ptr + k) % NCH].size() > 0) exp = (ptr + k) % NCH;
        checks++;
        if (left > 0 || exp < 0) begin
          errors++; $display("FAIL rand_hdr_unexpected: got header with %0d beats pending expected none", left);
        end else begin
          checks++; if (grant !== 2'(exp)) begin errors++; $display("FAIL rand_grant: got %0d expected %0d", grant, exp); end
          checks++; if (out_header !== hq[exp][0]) begin errors++; $display("FAIL rand_header: got %h expected %h", out_header, hq[exp][0]); end
          checks++; if (hdr_rdy !== NCH'(1 << exp)) begin errors++; $display("FAIL rand_hdr_rdy: got %b expected %b", hdr_rdy, NCH'(1 << exp)); end
          h = hq[exp].pop_front();
          cur = exp;
          left = exp_beats(h, DW);
          if (left == 0) begin ptr = (exp + 1) % NCH; done++; end
        end
      end else if (out_data_v && out_data_rdy) begin
        checks++;
        if (left == 0) begin
          errors++; $display("FAIL rand_data_unexpected: got beat %h expected no data", out_data);
        end else begin
          checks++; if (grant !== 2'(cur)) begin errors++; $display("FAIL rand_data_grant: got %0d expected %0d", grant, cur); end
          checks++; if (out_data !== dq[cur][0]) begin errors++; $display("FAIL rand_data: got %h expected %h", out_data, dq[cur][0]); end
          void'(dq[cur].pop_front());
          left--;
          if (left == 0) begin ptr = (cur + 1) % NCH; done++; end
        end
      end
      cyc++;
    end
    checks++; if (done != 1000) begin errors++; $display("FAIL rand_msgs: got %0d expected 1000", done); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_data();
    test_rr_order();
    test_long_burst();
    test_wide_beat();
    test_single_requester();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
